rc_pwm_capture: RTL and testbench
=================================

Name: rc_pwm_capture

Overview:
- Single-channel RC servo/receiver PWM pulse-width capture.
- Measures the high time of one asynchronous PWM input in microseconds and publishes a validated 16-bit width with a one-cycle ready strobe.
- Instantiated once per receiver channel, upstream of the Wishbone PWM register block, which reads o_pwm_value.
- Adds input synchronisation, range checking and signal-loss timeout.

Parameters:
- CLK_FREQ_HZ, 48000000, i_clk frequency. DIV = CLK_FREQ_HZ/1000000 must be an integer >= 2.
- MIN_US, 800, shortest accepted pulse in us.
- MAX_US, 2200, longest accepted pulse in us. Must satisfy MIN_US <= MAX_US < 65535.
- TIMEOUT_US, 25000, signal-loss timeout in us. Must be <= 65535.

Ports:
- i_clk  in  1  system clock.
- i_resetn  in  1  reset, asynchronous, active-low.
- i_pwm  in  1  asynchronous PWM input from receiver.
- o_pwm_value  out  16  last accepted pulse width in us.
- o_pwm_ready  out  1  one-cycle strobe when o_pwm_value updates.
- o_pwm_valid  out  1  level: a valid pulse was accepted within TIMEOUT_US.
- o_pwm_error  out  1  one-cycle strobe on a rejected pulse.

Behaviour:
- Reset (async assert, sync-released use):
  - Outputs: o_pwm_value=0, o_pwm_ready=0, o_pwm_valid=0, o_pwm_error=0.
  - Synchroniser flops reset to 0. State=WAIT_LOW. All counters 0.
- Input path:
  - 2-flop synchroniser, then a registered previous-value flop.
  - rise = sync & ~prev; fall = ~sync & prev.
- Microsecond tick:
  - Prescaler counts 0..DIV-1 and produces a tick on DIV-1.
  - Free-running except that it clears on rise.
- State WAIT_LOW:
  - Ignores all edges.
  - On sync==0, go to ARMED.
  - Guarantees that a pulse already in progress at reset or after an abort is never measured.
- State ARMED:
  - On rise: go to HIGH and clear us_cnt and the prescaler.
- State HIGH:
  - us_cnt (16 bit) increments on each tick. Measured width = floor(high cycles / DIV).
  - Synchroniser delay is identical on both edges, so the measurement is unbiased.
  - On fall with MIN_US <= us_cnt <= MAX_US:
    - o_pwm_value <= us_cnt; o_pwm_ready pulses 1 cycle; o_pwm_valid <= 1.
    - Timeout counter clears. Go to ARMED.
  - On fall with us_cnt < MIN_US:
    - o_pwm_error pulses 1 cycle. Value and valid are unchanged. Go to ARMED.
  - If us_cnt would exceed MAX_US while still high (stuck-high or overlong):
    - o_pwm_error pulses 1 cycle in that cycle; o_pwm_valid <= 0. Go to WAIT_LOW.
    - No ready strobe for that pulse.
- Latency: o_pwm_ready and o_pwm_value are visible 2 clocks after the first i_clk edge that samples i_pwm low.
- Timeout:
  - A 16-bit counter increments on each tick in every state and saturates at TIMEOUT_US.
  - On reaching TIMEOUT_US: o_pwm_valid <= 0 and o_pwm_value <= 0 (fail-safe). No strobe.
  - The counter clears only on an accepted pulse.
- Simultaneous events:
  - Accepted latch in the same cycle as timeout expiry: the latch wins (valid=1, value updated, counter cleared).
  - o_pwm_ready and o_pwm_error are never high in the same cycle.
- Reset mid-pulse: outputs clear immediately. The remainder of the current high pulse is discarded via WAIT_LOW.
- o_pwm_value holds its value between updates. Consumers may sample it at any time.

Test Plan:
- Nominal pulse (CLK_FREQ_HZ=10000000, DIV=10):
  - Stimulus: reset, i_pwm low 100 cycles, high 15000 cycles, low.
  - Required: o_pwm_value=1500; o_pwm_ready high exactly 1 cycle, 2 clocks after the low sample; o_pwm_valid=1.
- Range limits (same clock):
  - Stimulus: high pulses of 8000, 7990, 22000 and 22010 cycles.
  - Required: 800 accepted; 799 gives an error strobe and value stays 800; 2200 accepted.
  - Required for the 22010-cycle pulse: error strobe at us_cnt 2201 while still high, valid=0, value stays 2200, and the trailing fall produces no ready.
- Reset mid-pulse:
  - Stimulus: assert i_resetn low during a high pulse, release while i_pwm is still high.
  - Required: all outputs 0; no ready for that pulse; the next full 1200 us pulse gives value=1200.
- Timeout:
  - Stimulus: accepted 1500 us pulse, then i_pwm held low for 25000 us.
  - Required: valid drops and value becomes 0 at the 25000th tick after the accept; a new 1000 us pulse restores valid=1, value=1000.
- Back-to-back frames:
  - Stimulus: 50 pulses of 1000..2000 us with 2500 us low gaps.
  - Required: exactly 50 ready strobes, each value matching its pulse, zero error strobes.
- Glitch:
  - Stimulus: 3-cycle high spike while ARMED.
  - Required: error strobe, value unchanged, valid unchanged.

Source files
------------

// File: rtl/rc_pwm_capture.sv
// rc_pwm_capture
//   Single-channel RC servo/receiver PWM pulse-width capture. Measures the
//   high time of an asynchronous PWM input in microseconds, range-checks it
//   and publishes the accepted width with a one-cycle ready strobe. A
//   signal-loss timeout forces a fail-safe (valid=0, value=0) when no good
//   pulse has been seen for TIMEOUT_US.
//
// Ports
//   i_clk        system clock
//   i_resetn     asynchronous active-low reset
//   i_pwm        asynchronous PWM input
//   o_pwm_value  last accepted pulse width in us (held between updates)
//   o_pwm_ready  one-cycle strobe when o_pwm_value updates
//   o_pwm_valid  level: a valid pulse was accepted within TIMEOUT_US
//   o_pwm_error  one-cycle strobe on a rejected pulse
module rc_pwm_capture #(
  parameter int CLK_FREQ_HZ = 48000000,
  parameter int MIN_US      = 800,
  parameter int MAX_US      = 2200,
  parameter int TIMEOUT_US  = 25000
) (
  input  logic        i_clk,
  input  logic        i_resetn,
  input  logic        i_pwm,
  output logic [15:0] o_pwm_value,
  output logic        o_pwm_ready,
  output logic        o_pwm_valid,
  output logic        o_pwm_error
);

  localparam int              DIV      = CLK_FREQ_HZ / 1000000;
  localparam int              PW       = $clog2(DIV);
  localparam logic [PW-1:0]   PRE_LAST = PW'(DIV - 1);
  localparam logic [16:0]     MIN_W    = 17'(MIN_US);
  localparam logic [16:0]     MAX_W    = 17'(MAX_US);
  localparam logic [15:0]     TO_MAX   = 16'(TIMEOUT_US);
  localparam logic [15:0]     TO_PRE   = 16'(TIMEOUT_US - 1);

  typedef enum logic [1:0] {WAIT_LOW, ARMED, HIGH} state_t;

  // Saturating microsecond counter used for signal-loss timing.
  function automatic logic [15:0] sat_inc(input logic [15:0] cnt, input logic tick);
    if (tick && cnt != TO_MAX) return cnt + 16'd1;
    return cnt;
  endfunction

  logic          pwm_p0, pwm_p1, pwm_p2;
  logic [1:0]    fill;
  logic [PW-1:0] presc;
  logic [15:0]   us_cnt, to_cnt;
  state_t        state;

  logic        rise, fall, tick;
  logic [16:0] us_next;

  assign rise = pwm_p1 & ~pwm_p2;
  assign fall = ~pwm_p1 & pwm_p2;
  assign tick = (presc == PRE_LAST);
  // Including the current cycle's tick makes the width floor(high_cycles/DIV).
  assign us_next = {1'b0, us_cnt} + {16'd0, tick};

  // Stage p0/p1: two-flop synchroniser; p2: previous value for edge detect.
  // fill marks when pwm_p1 holds a genuine post-reset sample, so WAIT_LOW
  // cannot be satisfied by the reset value of the synchroniser.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      pwm_p0 <= 1'b0;
      pwm_p1 <= 1'b0;
      pwm_p2 <= 1'b0;
      fill   <= 2'd0;
      presc  <= '0;
    end else begin
      pwm_p0 <= i_pwm;
      pwm_p1 <= pwm_p0;
      pwm_p2 <= pwm_p1;
      if (fill != 2'd2) fill <= fill + 2'd1;
      if (rise || tick) presc <= '0;
      else              presc <= presc + PW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state       <= WAIT_LOW;
      us_cnt      <= 16'd0;
      to_cnt      <= 16'd0;
      o_pwm_value <= 16'd0;
      o_pwm_ready <= 1'b0;
      o_pwm_valid <= 1'b0;
      o_pwm_error <= 1'b0;
    end else begin
      o_pwm_ready <= 1'b0;
      o_pwm_error <= 1'b0;
      to_cnt      <= sat_inc(to_cnt, tick);
      if (tick && to_cnt == TO_PRE) begin
        o_pwm_valid <= 1'b0;
        o_pwm_value <= 16'd0;
      end
      case (state)
        WAIT_LOW: begin
          if (fill == 2'd2 && !pwm_p1) state <= ARMED;
        end
        ARMED: begin
          if (rise) begin
            us_cnt <= 16'd0;
            state  <= HIGH;
          end
        end
        HIGH: begin
          if (us_next > MAX_W) begin
            // Stuck-high or overlong: drop valid and ignore the rest of it.
            o_pwm_error <= 1'b1;
            o_pwm_valid <= 1'b0;
            state       <= WAIT_LOW;
          end else if (fall) begin
            state <= ARMED;
            if (us_next >= MIN_W) begin
              // Placed after the timeout update so an accept wins a tie.
              o_pwm_value <= us_next[15:0];
              o_pwm_ready <= 1'b1;
              o_pwm_valid <= 1'b1;
              to_cnt      <= 16'd0;
            end else begin
              o_pwm_error <= 1'b1;
            end
          end else begin
            us_cnt <= us_next[15:0];
          end
        end
        default: state <= WAIT_LOW;
      endcase
    end
  end

endmodule

// File: tb/tb_rc_pwm_capture.sv
module tb_rc_pwm_capture;

  localparam int DIV = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pwm = 1'b0;
  logic [15:0] pwm_value;
  logic        pwm_ready, pwm_valid, pwm_error;

  int checks = 0;
  int failures = 0;
  int rdy_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int last_ready_cyc = -1;
  int exp_q[$];

  rc_pwm_capture #(
    .CLK_FREQ_HZ(3000000),
    .MIN_US     (80),
    .MAX_US     (220),
    .TIMEOUT_US (2500)
  ) dut (
    .i_clk      (clk),
    .i_resetn   (rst_n),
    .i_pwm      (pwm),
    .o_pwm_value(pwm_value),
    .o_pwm_ready(pwm_ready),
    .o_pwm_valid(pwm_valid),
    .o_pwm_error(pwm_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every ready strobe must match the next expected width.
  always @(posedge clk) begin
    #2;
    if (pwm_error) err_cnt++;
    if (pwm_ready) begin
      rdy_cnt++;
      last_ready_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_ready: value=%0d with no pulse expected", pwm_value);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (pwm_value !== 16'(e) || pwm_valid !== 1'b1 || pwm_error !== 1'b0) begin
          failures++;
          $display("FAIL ready_value: got value=%0d valid=%b error=%b, expected value=%0d valid=1 error=0",
                   pwm_value, pwm_valid, pwm_error, e);
        end
      end
    end
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int n);
    pwm = 1'b1;
    hold(n);
    pwm = 1'b0;
  endtask

  task automatic check_outs(input string name, input int value, input logic valid);
    checks++;
    if (pwm_value !== 16'(value) || pwm_valid !== valid) begin
      failures++;
      $display("FAIL %s: got value=%0d valid=%b, expected value=%0d valid=%b",
               name, pwm_value, pwm_valid, value, valid);
    end
  endtask

  task automatic check_cnt(input string name, input int got, input int expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, got, expv);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    pwm   = 1'b0;
    hold(5);
    checks++;
    if ({pwm_value, pwm_ready, pwm_valid, pwm_error} !== 19'd0) begin
      failures++;
      $display("FAIL reset_outputs: got value=%0d ready=%b valid=%b error=%b, expected all 0",
               pwm_value, pwm_ready, pwm_valid, pwm_error);
    end
    rst_n = 1'b1;
    hold(10);
    check_outs("post_reset_idle", 0, 1'b0);
    check_cnt("post_reset_errors", err_cnt, 0);
  endtask

  task automatic test_nominal;
    int r0, c_low;
    hold(5);
    r0 = rdy_cnt;
    exp_q.push_back(150);
    pulse(150 * DIV);
    c_low = cyc + 1;           // next posedge is the first to sample low
    hold(10);
    check_cnt("nominal_ready_count", rdy_cnt - r0, 1);
    check_cnt("nominal_latency", last_ready_cyc, c_low + 2);
    check_outs("nominal_value", 150, 1'b1);
    check_cnt("nominal_queue_empty", exp_q.size(), 0);
  endtask

  task automatic test_glitch;
    int r0, e0;
    r0 = rdy_cnt;
    e0 = err_cnt;
    pulse(3);
    hold(10);
    check_cnt("glitch_error", err_cnt - e0, 1);
    check_cnt("glitch_no_ready", rdy_cnt - r0, 0);
    check_outs("glitch_hold", 150, 1'b1);
  endtask

  task automatic test_range;
    int cyc_tab[5] = '{240, 239, 242, 660, 663};
    int acc_tab[5] = '{1, 0, 1, 1, 0};
    int val_tab[5] = '{80, 80, 80, 220, 220};
    logic vld_tab[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    int r0, e0;
    for (int i = 0; i < 5; i++) begin
      r0 = rdy_cnt;
      e0 = err_cnt;
      if (acc_tab[i] != 0) exp_q.push_back(val_tab[i]);
      pulse(cyc_tab[i]);
      hold(20);
      check_cnt($sformatf("range_ready_%0d", cyc_tab[i]), rdy_cnt - r0, acc_tab[i]);
      check_cnt($sformatf("range_error_%0d", cyc_tab[i]), err_cnt - e0, 1 - acc_tab[i]);
      check_outs($sformatf("range_outs_%0d", cyc_tab[i]), val_tab[i], vld_tab[i]);
    end
    // Re-validate, then hold the line high well past MAX_US.
    exp_q.push_back(220);
    pulse(660);
    hold(20);
    check_outs("range_revalidate", 220, 1'b1);
    e0 = err_cnt;
    pwm = 1'b1;
    hold(250 * DIV);
    check_cnt("stuck_high_error", err_cnt - e0, 1);
    check_outs("stuck_high_outs", 220, 1'b0);
    r0 = rdy_cnt;
    pwm = 1'b0;
    hold(20);
    check_cnt("stuck_trailing_ready", rdy_cnt - r0, 0);
    check_cnt("stuck_trailing_error", err_cnt - e0, 1);
  endtask

  task automatic test_reset_mid;
    int r0, e0;
    hold(5);
    pwm = 1'b1;
    hold(200);
    rst_n = 1'b0;
    hold(3);
    checks++;
    if ({pwm_value, pwm_ready, pwm_valid, pwm_error} !== 19'd0) begin
      failures++;
      $display("FAIL reset_mid_outputs: got value=%0d ready=%b valid=%b error=%b, expected all 0",
               pwm_value, pwm_ready, pwm_valid, pwm_error);
    end
    rst_n = 1'b1;
    r0 = rdy_cnt;
    e0 = err_cnt;
    hold(300);
    pwm = 1'b0;
    hold(20);
    check_cnt("reset_mid_no_ready", rdy_cnt - r0, 0);
    check_cnt("reset_mid_no_error", err_cnt - e0, 0);
    exp_q.push_back(120);
    pulse(120 * DIV);
    hold(20);
    check_cnt("reset_mid_next_ready", rdy_cnt - r0, 1);
    check_outs("reset_mid_next_value", 120, 1'b1);
  endtask

  task automatic test_timeout;
    int r0;
    bit seen;
    r0 = rdy_cnt;
    exp_q.push_back(150);
    pulse(150 * DIV);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (rdy_cnt != r0) seen = 1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL timeout_accept_wait: got no ready within 20 cycles, expected one");
    end
    hold(2498 * DIV);
    check_outs("timeout_before", 150, 1'b1);
    hold(4 * DIV);
    check_outs("timeout_after", 0, 1'b0);
    exp_q.push_back(100);
    pulse(100 * DIV);
    hold(10);
    check_outs("timeout_recover", 100, 1'b1);
  endtask

  task automatic test_back_to_back;
    int r0, e0, w;
    r0 = rdy_cnt;
    e0 = err_cnt;
    for (int i = 0; i < 50; i++) begin
      w = 100 + (i * 100) / 49;
      exp_q.push_back(w);
      pulse(w * DIV + (i % DIV));   // extra sub-us cycles must floor away
      hold(100 * DIV);
    end
    check_cnt("b2b_ready_count", rdy_cnt - r0, 50);
    check_cnt("b2b_error_count", err_cnt - e0, 0);
    check_cnt("b2b_queue_empty", exp_q.size(), 0);
    check_outs("b2b_last_value", 200, 1'b1);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_nominal();
    test_glitch();
    test_range();
    test_reset_mid();
    test_timeout();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
